pixel_frame_sequencer: RTL and testbench

Frame-level controller that sequences one full image through the pixel operation unit (brighten, darken, threshold, invert). On a start request it latches the operation configuration, streams every pixel from source frame memory into the op unit, and writes each result to destination frame memory at the same address. It provides a start/busy/done handshake, abort, and a fixed-latency pipeline that tracks op-unit latency. It sits between the frame memories and the op unit, replacing bench-driven pixel feeding.

---
 rtl/pixel_frame_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
// Streams one full frame from source frame memory through the pixel op unit
// and writes each result back to destination frame memory at the same address.
// Optional feature macro: PIXSEQ_ROI_EN -- adds roi_start/roi_end ports; pixels
// outside the inclusive ROI are written with their original source value.
module pixel_frame_sequencer #(
    parameter int NUM_PIXELS = 98304,
    parameter int ADDR_W     = 17,
    parameter int OP_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        cfg_sel,
    input  logic [7:0]        cfg_value,
    input  logic [7:0]        cfg_threshold,
`ifdef PIXSEQ_ROI_EN
    input  logic [ADDR_W-1:0] roi_start,
    input  logic [ADDR_W-1:0] roi_end,
`endif
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_rd_data,
    output logic [7:0]        op_in,
    output logic [7:0]        op_value,
    output logic [7:0]        op_threshold,
    output logic [1:0]        op_sel,
    input  logic [7:0]        op_out,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [7:0]        dst_wr_data
);

    // One stage for the memory read, one for op_in, OP_LAT for the op unit.
    localparam int PIPE = OP_LAT + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    logic [1:0]        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              src_rd_en_q, src_rd_en_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic [7:0]        op_in_q, op_in_d;
    logic [1:0]        op_sel_q, op_sel_d;
    logic [7:0]        op_value_q, op_value_d;
    logic [7:0]        op_threshold_q, op_threshold_d;
    logic              dst_wr_en_q, dst_wr_en_d;
    logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
    logic [7:0]        dst_wr_data_q, dst_wr_data_d;
    logic [PIPE-1:0]   vld_q, vld_d;
    logic [ADDR_W-1:0] pipe_addr_q [PIPE];
    logic [ADDR_W-1:0] pipe_addr_d [PIPE];
    logic [7:0]        write_pixel;

`ifdef PIXSEQ_ROI_EN
    logic [ADDR_W-1:0] roi_start_q, roi_start_d;
    logic [ADDR_W-1:0] roi_end_q, roi_end_d;
    logic [7:0]        pix_q [OP_LAT+1];
    logic [7:0]        pix_d [OP_LAT+1];

    // Raw source pixels delayed so they line up with op_out at the write stage.
    always_comb begin
        pix_d[0] = src_rd_data;
        for (int k = 1; k <= OP_LAT; k++) begin
            pix_d[k] = pix_q[k-1];
        end
    end

    // Inside the ROI take the op result, outside it pass the original pixel.
    always_comb begin
        write_pixel = pix_q[OP_LAT];
        if (pipe_addr_q[PIPE-1] >= roi_start_q && pipe_addr_q[PIPE-1] <= roi_end_q) begin
            write_pixel = op_out;
        end
    end
`else
    // Without ROI support every pixel is written with the op result.
    always_comb begin
        write_pixel = op_out;
    end
`endif

    // Frame FSM, read address generation and the valid/address tracking pipe.
    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        aborted_d      = 1'b0;
        src_rd_en_d    = src_rd_en_q;
        src_addr_d     = src_addr_q;
        op_sel_d       = op_sel_q;
        op_value_d     = op_value_q;
        op_threshold_d = op_threshold_q;
`ifdef PIXSEQ_ROI_EN
        roi_start_d    = roi_start_q;
        roi_end_d      = roi_end_q;
`endif
        vld_d          = {vld_q[PIPE-2:0], src_rd_en_q};
        pipe_addr_d[0] = src_addr_q;
        for (int k = 1; k < PIPE; k++) begin
            pipe_addr_d[k] = pipe_addr_q[k-1];
        end
        op_in_d       = vld_q[0] ? src_rd_data : op_in_q;
        dst_wr_en_d   = vld_q[PIPE-1];
        dst_addr_d    = vld_q[PIPE-1] ? pipe_addr_q[PIPE-1] : dst_addr_q;
        dst_wr_data_d = vld_q[PIPE-1] ? write_pixel : dst_wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_RUN;
                    busy_d         = 1'b1;
                    src_rd_en_d    = 1'b1;
                    src_addr_d     = '0;
                    op_sel_d       = cfg_sel;
                    op_value_d     = cfg_value;
                    op_threshold_d = cfg_threshold;
`ifdef PIXSEQ_ROI_EN
                    roi_start_d    = roi_start;
                    roi_end_d      = roi_end;
`endif
                end
            end
            ST_RUN: begin
                if (src_addr_q == LAST_ADDR) begin
                    state_d     = ST_DRAIN;
                    src_rd_en_d = 1'b0;
                end else begin
                    src_addr_d = src_addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (vld_q == '0 && !src_rd_en_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything while busy: stop reads, kill in-flight writes.
        if (busy_q && abort) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            aborted_d   = 1'b1;
            src_rd_en_d = 1'b0;
            vld_d       = '0;
            dst_wr_en_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            src_rd_en_q    <= 1'b0;
            src_addr_q     <= '0;
            op_in_q        <= '0;
            op_sel_q       <= '0;
            op_value_q     <= '0;
            op_threshold_q <= '0;
            dst_wr_en_q    <= 1'b0;
            dst_addr_q     <= '0;
            dst_wr_data_q  <= '0;
            vld_q          <= '0;
            for (int k = 0; k < PIPE; k++) begin
                pipe_addr_q[k] <= '0;
            end
`ifdef PIXSEQ_ROI_EN
            roi_start_q    <= '0;
            roi_end_q      <= '0;
            for (int k = 0; k <= OP_LAT; k++) begin
                pix_q[k] <= '0;
            end
`endif
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
            src_rd_en_q    <= src_rd_en_d;
            src_addr_q     <= src_addr_d;
            op_in_q        <= op_in_d;
            op_sel_q       <= op_sel_d;
            op_value_q     <= op_value_d;
            op_threshold_q <= op_threshold_d;
            dst_wr_en_q    <= dst_wr_en_d;
            dst_addr_q     <= dst_addr_d;
            dst_wr_data_q  <= dst_wr_data_d;
            vld_q          <= vld_d;
            pipe_addr_q    <= pipe_addr_d;
`ifdef PIXSEQ_ROI_EN
            roi_start_q    <= roi_start_d;
            roi_end_q      <= roi_end_d;
            pix_q          <= pix_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign src_rd_en    = src_rd_en_q;
    assign src_addr     = src_addr_q;
    assign op_in        = op_in_q;
    assign op_sel       = op_sel_q;
    assign op_value     = op_value_q;
    assign op_threshold = op_threshold_q;
    assign dst_wr_en    = dst_wr_en_q;
    assign dst_addr     = dst_addr_q;
    assign dst_wr_data  = dst_wr_data_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Testbench for pixel_frame_sequencer: two instances (OP_LAT=1 and OP_LAT=3)
// with small frames, behavioural frame memories and op units, and a write
// scoreboard per instance.
module tb_pixel_frame_sequencer;

    localparam int N  = 16;
    localparam int AW = 5;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          start_a;
    logic          start_b;
    logic          abort;
    logic [1:0]    cfg_sel;
    logic [7:0]    cfg_value;
    logic [7:0]    cfg_threshold;
`ifdef PIXSEQ_ROI_EN
    logic [AW-1:0] roi_start;
    logic [AW-1:0] roi_end;
`endif

    logic          busy_a, done_a, aborted_a, src_rd_en_a, dst_wr_en_a;
    logic [AW-1:0] src_addr_a, dst_addr_a;
    logic [7:0]    src_rd_data_a, op_in_a, op_value_a, op_threshold_a, op_out_a, dst_wr_data_a;
    logic [1:0]    op_sel_a;

    logic          busy_b, done_b, aborted_b, src_rd_en_b, dst_wr_en_b;
    logic [AW-1:0] src_addr_b, dst_addr_b;
    logic [7:0]    src_rd_data_b, op_in_b, op_value_b, op_threshold_b, op_out_b, dst_wr_data_b;
    logic [1:0]    op_sel_b;
    logic [7:0]    op_pipe_b [2];

    logic [7:0]    src_mem [N];
    int            cnt = 0;
    int            total = 0;
    int            bad = 0;
    wr_t           exp_a[$];
    wr_t           obs_a[$];
    wr_t           exp_b[$];
    wr_t           obs_b[$];

    pixel_frame_sequencer #(.NUM_PIXELS(N), .ADDR_W(AW), .OP_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .cfg_sel(cfg_sel), .cfg_value(cfg_value), .cfg_threshold(cfg_threshold),
`ifdef PIXSEQ_ROI_EN
        .roi_start(roi_start), .roi_end(roi_end),
`endif
        .busy(busy_a), .done(done_a), .aborted(aborted_a),
        .src_rd_en(src_rd_en_a), .src_addr(src_addr_a), .src_rd_data(src_rd_data_a),
        .op_in(op_in_a), .op_value(op_value_a), .op_threshold(op_threshold_a),
        .op_sel(op_sel_a), .op_out(op_out_a),
        .dst_wr_en(dst_wr_en_a), .dst_addr(dst_addr_a), .dst_wr_data(dst_wr_data_a)
    );

    pixel_frame_sequencer #(.NUM_PIXELS(N), .ADDR_W(AW), .OP_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .cfg_sel(cfg_sel), .cfg_value(cfg_value), .cfg_threshold(cfg_threshold),
`ifdef PIXSEQ_ROI_EN
        .roi_start(roi_start), .roi_end(roi_end),
`endif
        .busy(busy_b), .done(done_b), .aborted(aborted_b),
        .src_rd_en(src_rd_en_b), .src_addr(src_addr_b), .src_rd_data(src_rd_data_b),
        .op_in(op_in_b), .op_value(op_value_b), .op_threshold(op_threshold_b),
        .op_sel(op_sel_b), .op_out(op_out_b),
        .dst_wr_en(dst_wr_en_b), .dst_addr(dst_addr_b), .dst_wr_data(dst_wr_data_b)
    );

    // Reference pixel operation used both by the op-unit models and for expectations.
    function automatic logic [7:0] op_f(input logic [1:0] s, input logic [7:0] v,
                                        input logic [7:0] t, input logic [7:0] x);
        int r;
        case (s)
            2'b00:   r = (int'(x) + int'(v) > 255) ? 255 : int'(x) + int'(v);
            2'b01:   r = (int'(x) < int'(v)) ? 0 : int'(x) - int'(v);
            2'b10:   r = (x >= t) ? 255 : 0;
            default: r = 255 - int'(x);
        endcase
        return 8'(r);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    // Source frame memories: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (src_rd_en_a) src_rd_data_a <= src_mem[src_addr_a[3:0]];
        if (src_rd_en_b) src_rd_data_b <= src_mem[src_addr_b[3:0]];
    end

    // Op units: latency 1 for instance a, latency 3 for instance b.
    always @(posedge clk) begin
        op_out_a     <= op_f(op_sel_a, op_value_a, op_threshold_a, op_in_a);
        op_pipe_b[0] <= op_f(op_sel_b, op_value_b, op_threshold_b, op_in_b);
        op_pipe_b[1] <= op_pipe_b[0];
        op_out_b     <= op_pipe_b[1];
    end

    // Destination write recorders.
    always @(negedge clk) begin
        if (dst_wr_en_a) obs_a.push_back({32'(cnt), dst_addr_a, dst_wr_data_a});
        if (dst_wr_en_b) obs_b.push_back({32'(cnt), dst_addr_b, dst_wr_data_b});
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy_a, done_a, aborted_a, src_rd_en_a, src_addr_a, op_in_a, op_sel_a, op_value_a,
             op_threshold_a, dst_wr_en_a, dst_addr_a, dst_wr_data_a} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_a: outputs not all zero (busy=%b rd_en=%b wr_en=%b op_sel=%0d)",
                     busy_a, src_rd_en_a, dst_wr_en_a, op_sel_a);
        end
        total++;
        if ({busy_b, done_b, aborted_b, src_rd_en_b, src_addr_b, op_in_b, op_sel_b, op_value_b,
             op_threshold_b, dst_wr_en_b, dst_addr_b, dst_wr_data_b} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_b: outputs not all zero (busy=%b rd_en=%b wr_en=%b op_sel=%0d)",
                     busy_b, src_rd_en_b, dst_wr_en_b, op_sel_b);
        end
        rst = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({aborted_a, busy_a} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL idle_abort: aborted,busy=%b required 00", {aborted_a, busy_a});
        end
    endtask

    task automatic test_passthrough();
        int n0;
        wr_t e, o;
        for (int i = 0; i < N; i++) src_mem[i] = 8'(i);
        cfg_sel = 2'b00; cfg_value = 8'd0; cfg_threshold = 8'd0;
        start_a = 1'b1;
        n0 = cnt;
        for (int i = 0; i < N; i++) exp_a.push_back({32'(n0 + 5 + i), AW'(i), 8'(i)});
        for (int r = 1; r <= 24; r++) begin
            @(negedge clk);
            if (r == 1) start_a = 1'b0;
            total++;
            if (busy_a !== (r <= 20)) begin
                bad++;
                $display("[TB] FAIL pt_busy: cycle %0d busy=%b required %b", r, busy_a, r <= 20);
            end
            total++;
            if (done_a !== (r == 21)) begin
                bad++;
                $display("[TB] FAIL pt_done: cycle %0d done=%b required %b", r, done_a, r == 21);
            end
            total++;
            if (src_rd_en_a !== (r <= 16) || (r <= 16 && src_addr_a !== AW'(r - 1))) begin
                bad++;
                $display("[TB] FAIL pt_read: cycle %0d rd_en=%b addr=%0d required %b/%0d",
                         r, src_rd_en_a, src_addr_a, r <= 16, r - 1);
            end
        end
        @(negedge clk);
        total++;
        if (obs_a.size() !== exp_a.size()) begin
            bad++;
            $display("[TB] FAIL pt_count: writes=%0d required %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL pt_write: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                         o.cyc - n0, o.addr, o.data, e.cyc - n0, e.addr, e.data);
            end
        end
        exp_a.delete(); obs_a.delete();
    endtask

    task automatic test_invert_cfg_hold();
        int n0;
        wr_t e, o;
        for (int i = 0; i < N; i++) src_mem[i] = 8'(i * 16);
        cfg_sel = 2'b11; cfg_value = 8'd7; cfg_threshold = 8'd50;
        start_a = 1'b1;
        n0 = cnt;
        for (int i = 0; i < N; i++) exp_a.push_back({32'(n0 + 5 + i), AW'(i), 8'(255 - i * 16)});
        for (int r = 1; r <= 24; r++) begin
            @(negedge clk);
            if (r == 1) start_a = 1'b0;
            if (r == 5) begin cfg_sel = 2'b00; cfg_value = 8'd99; cfg_threshold = 8'd1; end
            total++;
            if ({op_sel_a, op_value_a, op_threshold_a} !== {2'b11, 8'd7, 8'd50}) begin
                bad++;
                $display("[TB] FAIL inv_cfg: cycle %0d sel=%0d val=%0d thr=%0d required 3/7/50",
                         r, op_sel_a, op_value_a, op_threshold_a);
            end
        end
        @(negedge clk);
        total++;
        if (obs_a.size() !== exp_a.size()) begin
            bad++;
            $display("[TB] FAIL inv_count: writes=%0d required %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL inv_write: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                         o.cyc - n0, o.addr, o.data, e.cyc - n0, e.addr, e.data);
            end
        end
        exp_a.delete(); obs_a.delete();
    endtask

    task automatic test_latency3();
        int n0;
        wr_t e, o;
        for (int i = 0; i < N; i++) src_mem[i] = 8'(i * 3);
        cfg_sel = 2'b00; cfg_value = 8'd10; cfg_threshold = 8'd0;
        start_b = 1'b1;
        n0 = cnt;
        for (int i = 0; i < N; i++) exp_b.push_back({32'(n0 + 7 + i), AW'(i), 8'(i * 3 + 10)});
        for (int r = 1; r <= 26; r++) begin
            @(negedge clk);
            if (r == 1) start_b = 1'b0;
            total++;
            if ({busy_b, done_b} !== {r <= 22, r == 23}) begin
                bad++;
                $display("[TB] FAIL l3_handshake: cycle %0d busy,done=%b%b required %b%b",
                         r, busy_b, done_b, r <= 22, r == 23);
            end
            if (r >= 3 && r <= 18) begin
                total++;
                if (op_in_b !== 8'((r - 3) * 3)) begin
                    bad++;
                    $display("[TB] FAIL l3_op_in: cycle %0d op_in=%0d required %0d", r, op_in_b, (r - 3) * 3);
                end
            end
        end
        @(negedge clk);
        total++;
        if (obs_b.size() !== exp_b.size()) begin
            bad++;
            $display("[TB] FAIL l3_count: writes=%0d required %0d", obs_b.size(), exp_b.size());
        end
        while (exp_b.size() > 0 && obs_b.size() > 0) begin
            e = exp_b.pop_front(); o = obs_b.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL l3_write: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                         o.cyc - n0, o.addr, o.data, e.cyc - n0, e.addr, e.data);
            end
        end
        exp_b.delete(); obs_b.delete();
    endtask

    task automatic test_abort();
        int n0;
        wr_t e, o;
        for (int i = 0; i < N; i++) src_mem[i] = 8'(100 + i);
        cfg_sel = 2'b00; cfg_value = 8'd0; cfg_threshold = 8'd0;
        start_a = 1'b1;
        n0 = cnt;
        for (int i = 0; 5 + i <= 8; i++) exp_a.push_back({32'(n0 + 5 + i), AW'(i), 8'(100 + i)});
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            if (r == 1) start_a = 1'b0;
            if (r == 9) abort = 1'b0;
            total++;
            if ({busy_a, aborted_a, done_a, src_rd_en_a} !== {r <= 8, r == 9, 1'b0, r <= 8}) begin
                bad++;
                $display("[TB] FAIL ab_ctrl: cycle %0d busy,aborted,done,rd_en=%b%b%b%b required %b%b0%b",
                         r, busy_a, aborted_a, done_a, src_rd_en_a, r <= 8, r == 9, r <= 8);
            end
            if (r == 8) abort = 1'b1;
        end
        total++;
        if (obs_a.size() !== exp_a.size()) begin
            bad++;
            $display("[TB] FAIL ab_count: writes=%0d required %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL ab_write: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                         o.cyc - n0, o.addr, o.data, e.cyc - n0, e.addr, e.data);
            end
        end
        exp_a.delete(); obs_a.delete();
        // Restart at cycle 10 and require a full frame.
        start_a = 1'b1;
        n0 = cnt;
        for (int i = 0; i < N; i++) exp_a.push_back({32'(n0 + 5 + i), AW'(i), 8'(100 + i)});
        for (int r = 1; r <= 23; r++) begin
            @(negedge clk);
            if (r == 1) start_a = 1'b0;
            total++;
            if ({busy_a, done_a} !== {r <= 20, r == 21}) begin
                bad++;
                $display("[TB] FAIL ab_restart: cycle %0d busy,done=%b%b required %b%b",
                         r, busy_a, done_a, r <= 20, r == 21);
            end
        end
        @(negedge clk);
        total++;
        if (obs_a.size() !== exp_a.size()) begin
            bad++;
            $display("[TB] FAIL ab_re_count: writes=%0d required %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL ab_re_write: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                         o.cyc - n0, o.addr, o.data, e.cyc - n0, e.addr, e.data);
            end
        end
        exp_a.delete(); obs_a.delete();
    endtask

    task automatic test_back_to_back();
        int n0;
        wr_t e, o;
        for (int i = 0; i < N; i++) src_mem[i] = 8'(200 - i);
        cfg_sel = 2'b01; cfg_value = 8'd190; cfg_threshold = 8'd0;
        start_a = 1'b1;
        n0 = cnt;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N; i++)
                exp_a.push_back({32'(n0 + f * 21 + 5 + i), AW'(i), 8'((200 - i > 190) ? 10 - i : 0)});
        for (int r = 1; r <= 46; r++) begin
            @(negedge clk);
            if (r == 22) start_a = 1'b0;
            if (r == 30) start_a = 1'b1;
            if (r == 31) start_a = 1'b0;
            total++;
            if ({busy_a, done_a} !== {(r <= 20) || (r >= 22 && r <= 41), (r == 21) || (r == 42)}) begin
                bad++;
                $display("[TB] FAIL b2b_handshake: cycle %0d busy,done=%b%b required %b%b", r, busy_a, done_a,
                         (r <= 20) || (r >= 22 && r <= 41), (r == 21) || (r == 42));
            end
        end
        total++;
        if (obs_a.size() !== exp_a.size()) begin
            bad++;
            $display("[TB] FAIL b2b_count: writes=%0d required %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL b2b_write: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                         o.cyc - n0, o.addr, o.data, e.cyc - n0, e.addr, e.data);
            end
        end
        exp_a.delete(); obs_a.delete();
    endtask

`ifdef PIXSEQ_ROI_EN
    task automatic test_roi();
        int n0;
        wr_t e, o;
        for (int i = 0; i < N; i++) src_mem[i] = 8'(i);
        cfg_sel = 2'b11; cfg_value = 8'd0; cfg_threshold = 8'd0;
        roi_start = AW'(4); roi_end = AW'(7);
        start_a = 1'b1;
        n0 = cnt;
        for (int i = 0; i < N; i++)
            exp_a.push_back({32'(n0 + 5 + i), AW'(i), (i >= 4 && i <= 7) ? 8'(255 - i) : 8'(i)});
        for (int r = 1; r <= 23; r++) begin
            @(negedge clk);
            if (r == 1) begin start_a = 1'b0; roi_start = '0; roi_end = '1; end
        end
        total++;
        if (obs_a.size() !== exp_a.size()) begin
            bad++;
            $display("[TB] FAIL roi_count: writes=%0d required %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL roi_write: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                         o.cyc - n0, o.addr, o.data, e.cyc - n0, e.addr, e.data);
            end
        end
        exp_a.delete(); obs_a.delete();
    endtask
`endif

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        cfg_sel = 2'b00; cfg_value = 8'd0; cfg_threshold = 8'd0;
`ifdef PIXSEQ_ROI_EN
        roi_start = '0; roi_end = '1;
`endif
        for (int i = 0; i < N; i++) src_mem[i] = 8'd0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_passthrough();
        test_invert_cfg_hold();
        test_latency3();
        test_abort();
        test_back_to_back();
`ifdef PIXSEQ_ROI_EN
        test_roi();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
